// File: rtl/pattern_scheduler.sv
// rtl/pattern_scheduler.sv - frame-synchronous demo pattern sequencer with brightness fades
module pattern_scheduler #(
  parameter int DUR0 = 240,
  parameter int DUR1 = 480,
  parameter int DUR2 = 360
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_pause,
  input  logic       btn_speed,
  input  logic       auto_en,
  output logic [1:0] pattern_select,
  output logic       paused,
  output logic [2:0] step_size,
  output logic [1:0] brightness,
  output logic       frame_start,
  output logic       busy
);
  typedef enum logic [1:0] {SHOW, FADE_OUT, FADE_IN} state_t;
  typedef enum logic [1:0] {NAV_NONE, NAV_NEXT, NAV_PREV} nav_t;

  state_t     state;
  nav_t       pending;
  logic       dir_prev;
  logic [9:0] frame_counter;
  logic [9:0] frame_last;
  logic [1:0] pattern_step;
  logic       vsync_q;
  logic       tick;
  // Button bit order: 0 next, 1 prev, 2 pause, 3 speed
  logic [3:0] btn_raw;
  logic [3:0] sync1, sync2, sync3, evt;

  assign tick    = vsync & ~vsync_q;
  assign btn_raw = {btn_speed, btn_pause, btn_prev, btn_next};

  always_comb begin
    case (pattern_select)
      2'd1:    frame_last = 10'(DUR1) - 10'd1;
      2'd2:    frame_last = 10'(DUR2) - 10'd1;
      default: frame_last = 10'(DUR0) - 10'd1;
    endcase
    if (dir_prev) pattern_step = (pattern_select == 2'd0) ? 2'd2 : pattern_select - 2'd1;
    else          pattern_step = (pattern_select == 2'd2) ? 2'd0 : pattern_select + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b1;
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      evt     <= '0;
    end else begin
      vsync_q <= vsync;
      sync1   <= btn_raw;
      sync2   <= sync1;
      sync3   <= sync2;
      evt     <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SHOW;
      pending        <= NAV_NONE;
      dir_prev       <= 1'b0;
      frame_counter  <= '0;
      pattern_select <= 2'd0;
      paused         <= 1'b0;
      step_size      <= 3'd1;
      brightness     <= 2'd3;
      frame_start    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      frame_start <= tick && !paused && (state == SHOW);
      if (tick) begin
        case (state)
          SHOW: begin
            if (pending != NAV_NONE) begin
              dir_prev   <= (pending == NAV_PREV);
              pending    <= NAV_NONE;
              state      <= FADE_OUT;
              busy       <= 1'b1;
              brightness <= 2'd2;
            end else if (auto_en && !paused && frame_counter == frame_last) begin
              dir_prev   <= 1'b0;
              state      <= FADE_OUT;
              busy       <= 1'b1;
              brightness <= 2'd2;
            end else if (!paused) begin
              frame_counter <= frame_counter + 10'd1;
            end
          end
          FADE_OUT: begin
            if (brightness == 2'd0) begin
              pattern_select <= pattern_step;
              frame_counter  <= '0;
              state          <= FADE_IN;
            end else begin
              brightness <= brightness - 2'd1;
            end
          end
          FADE_IN: begin
            brightness <= brightness + 2'd1;
            if (brightness == 2'd2) begin
              state <= SHOW;
              busy  <= 1'b0;
            end
          end
          default: state <= SHOW;
        endcase
      end
      // A fresh nav event overrides the consumption above, so it is never lost
      if (evt[0])      pending <= NAV_NEXT;
      else if (evt[1]) pending <= NAV_PREV;
      if (evt[2]) paused <= ~paused;
      if (evt[3]) step_size <= (step_size == 3'd7) ? 3'd1 : step_size + 3'd1;
    end
  end
endmodule

// File: tb/tb_pattern_scheduler.sv
// tb/tb_pattern_scheduler.sv - directed and randomized checks of pattern_scheduler against a tick-level model
module tb_pattern_scheduler;
  localparam int D0 = 4;
  localparam int D1 = 5;
  localparam int D2 = 3;

  logic       clk = 1'b0;
  logic       rst, vsync, btn_next, btn_prev, btn_pause, btn_speed, auto_en;
  logic [1:0] pattern_select, brightness;
  logic [2:0] step_size;
  logic       paused, frame_start, busy;

  int vectors = 0;
  int miscompares = 0;

  int durs[3] = '{D0, D1, D2};
  int btab[7] = '{2, 1, 0, 0, 1, 2, 3};
  int m_pat, m_bright, m_step, m_counter, m_fade, m_pending, m_dir;
  bit m_paused, m_fs;

  pattern_scheduler #(.DUR0(D0), .DUR1(D1), .DUR2(D2)) dut (
    .clk(clk), .rst(rst), .vsync(vsync),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_pause(btn_pause), .btn_speed(btn_speed),
    .auto_en(auto_en),
    .pattern_select(pattern_select), .paused(paused), .step_size(step_size),
    .brightness(brightness), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pattern"}, pattern_select, m_pat);
    check({tag, ".bright"}, brightness, m_bright);
    check({tag, ".busy"}, busy, (m_fade >= 0) ? 1 : 0);
    check({tag, ".paused"}, paused, m_paused);
    check({tag, ".step"}, step_size, m_step);
  endtask

  task automatic model_reset();
    m_pat = 0; m_bright = 3; m_step = 1; m_counter = 0;
    m_fade = -1; m_pending = 0; m_dir = 1; m_paused = 0; m_fs = 0;
  endtask

  // Transition is a 7-tick script indexed by m_fade; -1 means showing
  task automatic model_tick();
    m_fs = (m_fade < 0) && !m_paused;
    if (m_fade >= 0) begin
      m_fade++;
      m_bright = btab[m_fade];
      if (m_fade == 3) begin
        m_pat = (m_dir == 2) ? (m_pat + 2) % 3 : (m_pat + 1) % 3;
        m_counter = 0;
      end
      if (m_fade == 6) m_fade = -1;
    end else if (m_pending != 0) begin
      m_dir = m_pending; m_pending = 0; m_fade = 0; m_bright = btab[0];
    end else if (auto_en && !m_paused && m_counter == durs[m_pat] - 1) begin
      m_dir = 1; m_fade = 0; m_bright = btab[0];
    end else if (!m_paused) begin
      m_counter++;
    end
  endtask

  task automatic do_tick(input string tag);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    @(posedge clk); #1;
    model_tick();
    check_all(tag);
    check({tag, ".fs"}, frame_start, m_fs);
    @(posedge clk); #1;
    check({tag, ".fs_end"}, frame_start, 0);
  endtask

  // which: 0 next, 1 prev, 2 pause, 3 speed, 4 next+prev together
  task automatic press(input int which, input string tag);
    @(negedge clk);
    btn_next  = (which == 0 || which == 4);
    btn_prev  = (which == 1 || which == 4);
    btn_pause = (which == 2);
    btn_speed = (which == 3);
    repeat (3) @(posedge clk);
    #1;
    check_all({tag, ".early"});
    @(posedge clk); #1;
    case (which)
      0, 4: m_pending = 1;
      1: m_pending = 2;
      2: m_paused = !m_paused;
      3: m_step = (m_step == 7) ? 1 : m_step + 1;
      default: ;
    endcase
    check_all(tag);
    @(negedge clk);
    btn_next = 0; btn_prev = 0; btn_pause = 0; btn_speed = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".pattern"}, pattern_select, 0);
    check({tag, ".bright"}, brightness, 3);
    check({tag, ".step"}, step_size, 1);
    check({tag, ".paused"}, paused, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".fs"}, frame_start, 0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b1; auto_en = 1'b0;
    btn_next = 0; btn_prev = 0; btn_pause = 0; btn_speed = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle.fs", frame_start, 0);
    end
    check_reset_values("idle");

    auto_en = 1'b1;
    for (int i = 0; i < 40; i++) do_tick("auto");

    auto_en = 1'b0;
    press(1, "prev");
    for (int i = 0; i < 12; i++) do_tick("manual_prev");

    auto_en = 1'b1;
    press(2, "pause_on");
    for (int i = 0; i < 10; i++) do_tick("paused");
    press(2, "pause_off");
    for (int i = 0; i < 14; i++) do_tick("resume");

    for (int i = 0; i < 7; i++) press(3, "speed");

    for (int i = 0; i < 10 && m_fade >= 0; i++) do_tick("settle");
    auto_en = 1'b0;
    press(0, "next");
    do_tick("comb.T0");
    do_tick("comb.T1");
    press(0, "next_in_fade");
    for (int i = 2; i <= 6; i++) do_tick("comb.first");
    for (int i = 0; i <= 4; i++) do_tick("comb.second");
    async_reset("midfade_reset");

    press(4, "both_nav");
    for (int i = 0; i < 8; i++) do_tick("both_nav");

    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 10);
      if (r <= 5) do_tick("rnd");
      else if (r <= 9) press(r - 6, "rnd_press");
      else begin
        auto_en = $urandom_range(0, 1);
        do_tick("rnd_auto");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
